// File: rtl/burst_bus_arbiter.sv
// burst_bus_arbiter: shares one SDRAM burst port between the video line reader
// (read-only, high priority) and the CPU/blitter port (read/write, low priority,
// starvation-protected). Whole bursts are serialised. Read beats are steered to
// the burst owner, and CPU write beats are passed through while a write burst runs.
module burst_bus_arbiter #(
  parameter int ADDR_W       = 21,
  parameter int DATA_W       = 64,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                v_cmd_en,
  input  logic [ADDR_W-1:0]   v_addr,
  output logic                v_ack,
  output logic                v_rd_data_valid,
  output logic [DATA_W-1:0]   v_rd_data,
  input  logic                c_cmd_en,
  input  logic                c_cmd,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wr_data,
  input  logic [DATA_W/8-1:0] c_data_mask,
  output logic                c_ack,
  output logic                c_wr_data_req,
  output logic                c_rd_data_valid,
  output logic [DATA_W-1:0]   c_rd_data,
  output logic                m_cmd_en,
  output logic                m_cmd,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wr_data,
  output logic [DATA_W/8-1:0] m_data_mask,
  input  logic                m_busy,
  input  logic                m_rd_data_valid,
  input  logic [DATA_W-1:0]   m_rd_data,
  output logic                err_stray
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, WRITE_DATA} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = CPU owns the current burst
  logic                cmd_q, cmd_d;       // 1 = write
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic                err_q, err_d;

  // State and latched-command registers; async reset returns everything to IDLE/0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cmd_q    <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // Next-state, arbitration and all outputs; every output is 0 unless its state drives it.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    cmd_d           = cmd_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    starve_d        = starve_q;
    err_d           = err_q;
    v_ack           = 1'b0;
    c_ack           = 1'b0;
    v_rd_data_valid = 1'b0;
    c_rd_data_valid = 1'b0;
    v_rd_data       = '0;
    c_rd_data       = '0;
    c_wr_data_req   = 1'b0;
    m_cmd_en        = 1'b0;
    m_cmd           = 1'b0;
    m_addr          = '0;
    m_wr_data       = '0;
    m_data_mask     = '0;

    case (state_q)
      IDLE: begin
        if (!c_cmd_en) starve_d = '0;
        if (v_cmd_en || c_cmd_en) begin
          // CPU wins when alone, or when video has had its full run of grants.
          if (c_cmd_en && (!v_cmd_en || starve_q == STARVE_MAX)) begin
            owner_d = 1'b1;
            cmd_d   = c_cmd;
            addr_d  = c_addr;
          end else begin
            owner_d = 1'b0;
            cmd_d   = 1'b0;
            addr_d  = v_addr;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        m_cmd    = cmd_q;
        m_addr   = addr_q;
        m_cmd_en = !m_busy;
        if (!m_busy) begin
          beat_d = '0;
          if (owner_q) begin
            c_ack    = 1'b1;
            starve_d = '0;
          end else begin
            v_ack = 1'b1;
            if (c_cmd_en && starve_q != STARVE_MAX) starve_d = starve_q + SC_W'(1);
          end
          state_d = cmd_q ? WRITE_DATA : READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (m_rd_data_valid) begin
          // Data lines are zeroed for the non-owner so idle outputs stay quiet.
          if (owner_q) begin
            c_rd_data_valid = 1'b1;
            c_rd_data       = m_rd_data;
          end else begin
            v_rd_data_valid = 1'b1;
            v_rd_data       = m_rd_data;
          end
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      WRITE_DATA: begin
        // One beat per cycle; the controller is committed once the command is accepted.
        c_wr_data_req = 1'b1;
        m_wr_data     = c_wr_data;
        m_data_mask   = c_data_mask;
        beat_d        = beat_q + CNT_W'(1);
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (m_rd_data_valid && state_q != READ_WAIT) err_d = 1'b1;
    err_stray = err_q;
  end

endmodule

// File: tb/tb_burst_bus_arbiter.sv
// Bench for burst_bus_arbiter: a monitor/memory-model process checks grants,
// read beats and write beats against scoreboard queues filled by the test flow.
module tb_burst_bus_arbiter;
  localparam int AW = 21;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int BL = 4;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v_cmd_en, v_ack, v_rd_data_valid;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_rd_data;
  logic          c_cmd_en, c_cmd, c_ack, c_wr_data_req, c_rd_data_valid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wr_data, c_rd_data;
  logic [MW-1:0] c_data_mask;
  logic          m_cmd_en, m_cmd, m_busy, m_rd_data_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr_data, m_rd_data;
  logic [MW-1:0] m_data_mask;
  logic          err_stray;

  always #5 clk = ~clk;

  burst_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .v_cmd_en(v_cmd_en), .v_addr(v_addr), .v_ack(v_ack),
    .v_rd_data_valid(v_rd_data_valid), .v_rd_data(v_rd_data),
    .c_cmd_en(c_cmd_en), .c_cmd(c_cmd), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_data_mask(c_data_mask), .c_ack(c_ack), .c_wr_data_req(c_wr_data_req),
    .c_rd_data_valid(c_rd_data_valid), .c_rd_data(c_rd_data),
    .m_cmd_en(m_cmd_en), .m_cmd(m_cmd), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_data_mask(m_data_mask), .m_busy(m_busy), .m_rd_data_valid(m_rd_data_valid),
    .m_rd_data(m_rd_data), .err_stray(err_stray)
  );

  typedef struct packed {logic owner; logic cmd; logic [AW-1:0] addr;} grant_t;
  typedef struct packed {logic owner; logic [DW-1:0] data;} beat_t;

  grant_t grant_exp[$];
  beat_t  rd_exp[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  // shared between test flow and monitor
  logic [31:0] wr_base = 32'h0;
  int          stray_req = 0;
  int          rd_pend = 0, wr_win = 0, wr_idx = 0;
  int          v_beats = 0, c_beats = 0, w_beats = 0, n_grants = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic grant_t mk_grant(input logic owner, input logic cmd, input logic [AW-1:0] addr);
    grant_t g;
    g.owner = owner;
    g.cmd   = cmd;
    g.addr  = addr;
    return g;
  endfunction

  function automatic logic [DW-1:0] rd_beat(input logic [AW-1:0] a, input int b);
    return (64'(a) << 8) | (64'hA + 64'(b));
  endfunction

  function automatic logic [DW-1:0] wr_beat(input logic [31:0] base, input int i);
    return {16'hC0DE, 16'(i), base};
  endfunction

  function automatic logic [MW-1:0] wr_mask(input int i);
    logic [2:0] s;
    s = i[2:0];
    return 8'h80 | (8'h01 << s);
  endfunction

  // Monitor + memory model: checks on the falling edge, drives just after the rising edge.
  initial begin : monitor
    grant_t      g;
    beat_t       b;
    logic        owner_cur;
    logic [AW-1:0] rd_addr;
    bit          stray_cyc;
    int          stray_done;
    owner_cur = 1'b0; rd_addr = '0; stray_cyc = 1'b0; stray_done = 0;
    m_rd_data_valid = 1'b0; m_rd_data = '0; c_wr_data = '0; c_data_mask = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        grant_exp.delete();
        rd_exp.delete();
        rd_pend = 0; wr_win = 0; wr_idx = 0; stray_cyc = 1'b0;
      end else begin
        if (m_rd_data_valid && !stray_cyc) begin
          if (rd_exp.size() == 0) check("rd_sb_empty", 1, 0);
          else begin
            b = rd_exp.pop_front();
            check("rd_v_valid", v_rd_data_valid, !b.owner);
            check("rd_c_valid", c_rd_data_valid, b.owner);
            check("rd_data", b.owner ? c_rd_data : v_rd_data, b.data);
            if (v_rd_data_valid) v_beats++;
            if (c_rd_data_valid) c_beats++;
          end
        end else begin
          check("rd_quiet", {v_rd_data_valid, c_rd_data_valid}, 0);
        end
        stray_cyc = 1'b0;

        check("wr_req", c_wr_data_req, wr_win > 0);
        if (wr_win > 0) begin
          check("wr_data", m_wr_data, wr_beat(wr_base, wr_idx));
          check("wr_mask", m_data_mask, wr_mask(wr_idx));
          if (c_wr_data_req) w_beats++;
          wr_win--;
          wr_idx++;
        end

        if (m_busy) check("busy_no_cmd", m_cmd_en, 0);
        if (m_cmd_en) begin
          if (grant_exp.size() == 0) check("grant_sb_empty", 1, 0);
          else begin
            g = grant_exp.pop_front();
            n_grants++;
            check("grant_v_ack", v_ack, !g.owner);
            check("grant_c_ack", c_ack, g.owner);
            check("grant_cmd", m_cmd, g.cmd);
            check("grant_addr", m_addr, g.addr);
            owner_cur = g.owner;
            rd_addr   = g.addr;
            if (g.cmd) begin wr_win = BL; wr_idx = 0; end
            else rd_pend = BL;
          end
        end else begin
          check("ack_without_cmd", {v_ack, c_ack}, 0);
        end
      end

      @(posedge clk); #1;
      m_rd_data_valid = 1'b0;
      m_rd_data       = '0;
      if (rst_n && rd_pend > 0 && $urandom_range(0, 3) != 0) begin
        m_rd_data_valid = 1'b1;
        m_rd_data       = rd_beat(rd_addr, BL - rd_pend);
        b.owner = owner_cur;
        b.data  = m_rd_data;
        rd_exp.push_back(b);
        rd_pend--;
      end else if (rst_n && rd_pend == 0 && stray_req != stray_done) begin
        stray_done      = stray_req;
        m_rd_data_valid = 1'b1;
        m_rd_data       = 64'hBAD0_BAD0;
        stray_cyc       = 1'b1;
      end
      c_wr_data   = wr_beat(wr_base, wr_idx);
      c_data_mask = wr_mask(wr_idx);
    end
  end

  task automatic drain(input int budget, input string tag);
    int k = 0;
    while (k < budget && (grant_exp.size() != 0 || rd_exp.size() != 0 || rd_pend != 0 || wr_win != 0)) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_drain"}, k < budget, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_ack(input bit cpu, input int budget, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(cpu ? c_ack : v_ack) && k < budget);
    check({tag, "_ack"}, k < budget, 1);
    @(posedge clk); #1;
    if (cpu) c_cmd_en = 1'b0;
    else     v_cmd_en = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : test_flow
    int v0, c0, w0, k;
    rst_n = 1'b0; v_cmd_en = 1'b0; c_cmd_en = 1'b0; c_cmd = 1'b0;
    v_addr = '0; c_addr = '0; m_busy = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {m_cmd_en, m_cmd, v_ack, c_ack, c_wr_data_req, v_rd_data_valid, c_rd_data_valid, err_stray}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wr", {m_wr_data, m_data_mask}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // video read at 0x100, minimum latency
    v0 = v_beats; c0 = c_beats;
    grant_exp.push_back(mk_grant(1'b0, 1'b0, 21'h100));
    v_addr = 21'h100; v_cmd_en = 1'b1;
    @(negedge clk);
    check("t1_idle_cycle", {m_cmd_en, v_ack}, 2'b00);
    @(negedge clk);
    check("t1_issue_cycle", {m_cmd_en, v_ack, c_ack}, 3'b110);
    @(posedge clk); #1 v_cmd_en = 1'b0;
    drain(60, "t1");
    check("t1_vbeats", v_beats - v0, BL);
    check("t1_cbeats", c_beats - c0, 0);
    check("t1_err", err_stray, 0);

    // CPU write at 0x40 held off by m_busy for 3 cycles
    @(posedge clk); #1;
    w0 = w_beats;
    m_busy = 1'b1; wr_base = 32'h40;
    grant_exp.push_back(mk_grant(1'b1, 1'b1, 21'h40));
    c_cmd = 1'b1; c_addr = 21'h40; c_cmd_en = 1'b1;
    @(negedge clk);
    repeat (2) begin
      @(negedge clk);
      check("t2_busy_hold", {m_cmd_en, c_ack}, 2'b00);
      check("t2_fields", {m_cmd, m_addr}, {1'b1, 21'h40});
    end
    @(posedge clk); #1 m_busy = 1'b0;
    @(negedge clk);
    check("t2_accept", {m_cmd_en, c_ack, v_ack}, 3'b110);
    @(posedge clk); #1 c_cmd_en = 1'b0; m_busy = 1'b1;
    drain(40, "t2");
    m_busy = 1'b0;
    check("t2_wbeats", w_beats - w0, BL);

    // both requesting continuously: 8 video, 1 CPU, repeating
    @(posedge clk); #1;
    k = n_grants; c0 = c_beats; v0 = v_beats;
    repeat (2) begin
      for (int i = 0; i < SL; i++) grant_exp.push_back(mk_grant(1'b0, 1'b0, 21'h100));
      grant_exp.push_back(mk_grant(1'b1, 1'b0, 21'h80));
    end
    v_addr = 21'h100; c_cmd = 1'b0; c_addr = 21'h80;
    v_cmd_en = 1'b1; c_cmd_en = 1'b1;
    begin
      int t = 0;
      while (grant_exp.size() != 0 && t < 1500) begin
        @(negedge clk); #1;
        t++;
      end
      check("t3_grant_budget", t < 1500, 1);
    end
    @(posedge clk); #1 v_cmd_en = 1'b0; c_cmd_en = 1'b0;
    drain(60, "t3");
    check("t3_grants", n_grants - k, 2 * (SL + 1));
    check("t3_cbeats", c_beats - c0, 2 * BL);
    check("t3_vbeats", v_beats - v0, 2 * SL * BL);

    // stray read beat in IDLE sets a sticky error
    @(negedge clk);
    stray_req++;
    @(negedge clk);
    check("t4_err_before", err_stray, 0);
    @(negedge clk);
    check("t4_err_set", err_stray, 1);
    @(posedge clk); #1;
    grant_exp.push_back(mk_grant(1'b0, 1'b0, 21'h200));
    v_addr = 21'h200; v_cmd_en = 1'b1;
    wait_ack(1'b0, 20, "t4");
    drain(60, "t4");
    check("t4_err_sticky", err_stray, 1);

    // async reset during the second write beat, then a pending video request
    @(posedge clk); #1;
    wr_base = 32'h77;
    grant_exp.push_back(mk_grant(1'b1, 1'b1, 21'h44));
    c_cmd = 1'b1; c_addr = 21'h44; c_cmd_en = 1'b1;
    wait_ack(1'b1, 20, "t5");
    @(negedge clk);
    @(negedge clk);
    check("t5_beat2", c_wr_data_req, 1);
    #1 rst_n = 1'b0;
    v_addr = 21'h300; v_cmd_en = 1'b1;
    #1;
    check("t5_rst_ctrl", {m_cmd_en, m_cmd, v_ack, c_ack, c_wr_data_req, v_rd_data_valid, c_rd_data_valid, err_stray}, 0);
    check("t5_rst_data", {m_wr_data, m_data_mask, m_addr}, 0);
    repeat (2) @(negedge clk);
    #1 grant_exp.push_back(mk_grant(1'b0, 1'b0, 21'h300));
    v0 = v_beats;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ack(1'b0, 20, "t5_post");
    drain(60, "t5");
    check("t5_vbeats", v_beats - v0, BL);
    check("t5_err_cleared", err_stray, 0);
    check("end_queues", {32'(grant_exp.size()), 32'(rd_exp.size())}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
